mem_port_arbiter: RTL and testbench

- Initiator-side controller for the 32×16 single-port block RAM.
- Arbitrates between the instruction-fetch port and the load/store port and drives the RAM's `mem_write`, `address` and `write_data` inputs.
- Tracks the RAM's one-cycle registered-read latency and returns read data to whichever port issued the read.
- Sits between the datapath and the memory; it is the only block allowed to drive the RAM.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_arb_starve_cnt.sv | 37 +++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the block-RAM port arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating starvation counter: clear wins over increment, holds at LIMIT.
module mem_arb_starve_cnt #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [CNT_W-1:0] LimitVal = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && (r_cnt != LimitVal)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_at_limit = (r_cnt == LimitVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for a single-port RAM with one-cycle registered read.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W       = mem_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  import mem_pkg::*;

  owner_t r_rsp_owner;
  owner_t w_rsp_owner_nxt;
  logic   w_if_gnt;
  logic   w_ls_gnt;
  logic   w_at_limit;
  logic   w_starve_clr;
  logic   w_starve_inc;

  // Grants are forced low during reset so no RAM access or ready escapes.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (!reset) begin
      if (if_req && (!ls_req || w_at_limit)) begin
        w_if_gnt = 1'b1;
      end else if (ls_req) begin
        w_ls_gnt = 1'b1;
      end
    end
  end

  assign w_starve_clr = w_if_gnt | ~if_req;
  assign w_starve_inc = w_ls_gnt & if_req;

  mem_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (4)
  ) u_starve_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_starve_clr),
    .i_inc      (w_starve_inc),
    .o_at_limit (w_at_limit)
  );

  always_comb begin
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (w_if_gnt) begin
      mem_address = if_addr;
    end else if (w_ls_gnt) begin
      mem_address = ls_addr;
      if (ls_we) begin
        mem_write      = 1'b1;
        mem_write_data = ls_wdata;
      end
    end
  end

  always_comb begin
    w_rsp_owner_nxt = OWN_NONE;
    if (w_if_gnt) begin
      w_rsp_owner_nxt = OWN_IF;
    end else if (w_ls_gnt && !ls_we) begin
      w_rsp_owner_nxt = OWN_LS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_owner <= OWN_NONE;
    end else begin
      r_rsp_owner <= w_rsp_owner_nxt;
    end
  end

  assign if_ready  = w_if_gnt;
  assign ls_ready  = w_ls_gnt;
  assign if_rvalid = (r_rsp_owner == OWN_IF);
  assign ls_rvalid = (r_rsp_owner == OWN_LS);
  assign if_rdata  = mem_read_data;
  assign ls_rdata  = mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, reset corner case, then random traffic vs a model.
module tb_mem_port_arbiter;

  localparam int LIM = 4;
  localparam logic [1:0] GN = 2'b00;
  localparam logic [1:0] GI = 2'b01;
  localparam logic [1:0] GL = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [4:0]  if_addr, ls_addr;
  logic [15:0] ls_wdata;
  logic        if_ready, if_rvalid, ls_ready, ls_rvalid;
  logic [15:0] if_rdata, ls_rdata;
  logic        mem_write;
  logic [4:0]  mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (5),
    .DATA_W       (16),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_ready       (if_ready),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_ready       (ls_ready),
    .ls_rvalid      (ls_rvalid),
    .ls_rdata       (ls_rdata),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  function automatic logic [15:0] img(input int a);
    return 16'((a * 16'h0101) ^ 16'hA5A5);
  endfunction

  // Behavioural single-port RAM, write-first, registered read.
  logic [15:0] ram [32];
  initial for (int i = 0; i < 32; i++) ram[i] = img(i);
  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_address] <= mem_write_data;
      mem_read_data    <= mem_write_data;
    end else begin
      mem_read_data <= ram[mem_address];
    end
  end

  // Reference model state: memory image, fetch-waiting streak, pending response.
  logic [15:0] m_mem [32];
  int          m_starve;
  logic [1:0]  m_pend;
  logic [15:0] m_pend_data;
  logic [1:0]  m_last_g;

  typedef struct {
    logic        ifr;
    logic [4:0]  ifa;
    logic        lsr;
    logic        lsw;
    logic [4:0]  lsa;
    logic [15:0] lswd;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rsp;
    logic [15:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic ifr, input int ifa, input logic lsr, input logic lsw,
                              input int lsa, input logic [15:0] lswd, input logic [1:0] eg,
                              input logic [1:0] er, input logic [15:0] ed);
    vec_t v;
    v.ifr = ifr; v.ifa = 5'(ifa); v.lsr = lsr; v.lsw = lsw; v.lsa = 5'(lsa); v.lswd = lswd;
    v.exp_gnt = eg; v.exp_rsp = er; v.exp_rdata = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_grant(input vec_t v);
    if (v.ifr && v.lsr) return (m_starve == LIM) ? GI : GL;
    if (v.lsr) return GL;
    if (v.ifr) return GI;
    return GN;
  endfunction

  task automatic model_reset();
    m_starve = 0;
    m_pend   = GN;
    m_last_g = GN;
  endtask

  // Drive one cycle, check mid-cycle against the model (and the table if asked), advance model.
  task automatic step(input vec_t v, input bit use_tab);
    logic [1:0]  g;
    logic [4:0]  ea;
    logic        ew;
    logic [15:0] ed;
    if_req = v.ifr; if_addr = v.ifa;
    ls_req = v.lsr; ls_we = v.lsw; ls_addr = v.lsa; ls_wdata = v.lswd;
    @(negedge clk);
    g  = model_grant(v);
    ew = (g == GL) && v.lsw;
    ea = (g == GI) ? v.ifa : ((g == GL) ? v.lsa : 5'd0);
    ed = ew ? v.lswd : 16'd0;
    chk("grant", {30'd0, ls_ready, if_ready}, {30'd0, g});
    chk("mem_write", {31'd0, mem_write}, {31'd0, ew});
    chk("mem_address", {27'd0, mem_address}, {27'd0, ea});
    chk("mem_write_data", {16'd0, mem_write_data}, {16'd0, ed});
    chk("rvalid", {30'd0, ls_rvalid, if_rvalid}, {30'd0, m_pend});
    if (m_pend == GI) chk("if_rdata", {16'd0, if_rdata}, {16'd0, m_pend_data});
    if (m_pend == GL) chk("ls_rdata", {16'd0, ls_rdata}, {16'd0, m_pend_data});
    if (use_tab) begin
      chk("tab_grant", {30'd0, ls_ready, if_ready}, {30'd0, v.exp_gnt});
      chk("tab_rvalid", {30'd0, ls_rvalid, if_rvalid}, {30'd0, v.exp_rsp});
      if (v.exp_rsp == GI) chk("tab_if_rdata", {16'd0, if_rdata}, {16'd0, v.exp_rdata});
      if (v.exp_rsp == GL) chk("tab_ls_rdata", {16'd0, ls_rdata}, {16'd0, v.exp_rdata});
    end
    m_pend = GN;
    if (g == GI) begin
      m_pend = GI; m_pend_data = m_mem[v.ifa];
    end else if (g == GL && !v.lsw) begin
      m_pend = GL; m_pend_data = m_mem[v.lsa];
    end else if (g == GL) begin
      m_mem[v.lsa] = v.lswd;
    end
    if (g == GI || !v.ifr) m_starve = 0;
    else if (g == GL && m_starve < LIM) m_starve++;
    m_last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", {27'd0, mem_address}, 32'd0);
    chk("rst_mem_write_data", {16'd0, mem_write_data}, 32'd0);
  endtask

  vec_t tab [26];
  vec_t cur, prev;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = img(i);
    model_reset();

    tab[0]  = mk(1, 0,  0, 0, 0,  0,        GI, GN, 0);
    tab[1]  = mk(1, 1,  0, 0, 0,  0,        GI, GI, img(0));
    tab[2]  = mk(1, 2,  0, 0, 0,  0,        GI, GI, img(1));
    tab[3]  = mk(0, 0,  0, 0, 0,  0,        GN, GI, img(2));
    tab[4]  = mk(0, 0,  1, 1, 20, 16'hBEEF, GL, GN, 0);
    tab[5]  = mk(0, 0,  1, 0, 20, 0,        GL, GN, 0);
    tab[6]  = mk(0, 0,  0, 0, 0,  0,        GN, GL, 16'hBEEF);
    tab[7]  = mk(1, 5,  0, 0, 0,  0,        GI, GN, 0);
    tab[8]  = mk(0, 0,  1, 0, 6,  0,        GL, GI, img(5));
    tab[9]  = mk(1, 5,  0, 0, 0,  0,        GI, GL, img(6));
    tab[10] = mk(0, 0,  1, 0, 6,  0,        GL, GI, img(5));
    tab[11] = mk(0, 0,  0, 0, 0,  0,        GN, GL, img(6));
    tab[12] = mk(1, 7,  1, 0, 8,  0,        GL, GN, 0);
    tab[13] = mk(1, 7,  1, 0, 8,  0,        GL, GL, img(8));
    tab[14] = mk(1, 7,  1, 0, 8,  0,        GL, GL, img(8));
    tab[15] = mk(1, 7,  1, 0, 8,  0,        GL, GL, img(8));
    tab[16] = mk(1, 7,  1, 0, 8,  0,        GI, GL, img(8));
    tab[17] = mk(1, 7,  1, 0, 8,  0,        GL, GI, img(7));
    tab[18] = mk(1, 7,  1, 0, 8,  0,        GL, GL, img(8));
    tab[19] = mk(1, 7,  1, 0, 8,  0,        GL, GL, img(8));
    tab[20] = mk(1, 7,  1, 0, 8,  0,        GL, GL, img(8));
    tab[21] = mk(1, 7,  1, 0, 8,  0,        GI, GL, img(8));
    tab[22] = mk(0, 0,  0, 0, 0,  0,        GN, GI, img(7));
    tab[23] = mk(1, 31, 0, 0, 0,  0,        GI, GN, 0);
    tab[24] = mk(0, 0,  1, 0, 0,  0,        GL, GI, img(31));
    tab[25] = mk(0, 0,  0, 0, 0,  0,        GN, GL, img(0));

    // Reset with both requests asserted: nothing may be granted.
    reset = 1'b1;
    if_req = 1'b1; if_addr = 5'd3; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 5'd4;
    ls_wdata = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 26; i++) step(tab[i], 1'b1);

    // Reset right after a load is accepted drops its response.
    step(mk(0, 0, 1, 0, 3, 0, GL, GN, 0), 1'b1);
    reset = 1'b1;
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 5'd3; ls_wdata = 16'hDEAD;
    #1;
    chk("rst_drop_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    step(mk(0, 0, 1, 0, 3, 0, GL, GN, 0), 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, GN, GL, img(3)), 1'b1);

    // Random traffic; a losing requester holds its request stable.
    prev = mk(0, 0, 0, 0, 0, 0, GN, GN, 0);
    for (int c = 0; c < 400; c++) begin
      cur = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 31),
               ($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom_range(0, 31),
               16'($urandom), GN, GN, 0);
      if (prev.ifr && m_last_g != GI) begin
        cur.ifr = prev.ifr; cur.ifa = prev.ifa;
      end
      if (prev.lsr && m_last_g != GL) begin
        cur.lsr = prev.lsr; cur.lsw = prev.lsw; cur.lsa = prev.lsa; cur.lswd = prev.lswd;
      end
      step(cur, 1'b0);
      prev = cur;
    end
    step(mk(0, 0, 0, 0, 0, 0, GN, GN, 0), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
